fp_addsub_pipe: RTL

Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor with valid/ready handshaking on both sides. It is the clocked successor to the team's combinational double-precision adder. Exponent and mantissa widths are generic, so one block serves binary32 and binary64 datapaths. It also adds a true subtract mode, full gradual-underflow support, round-to-nearest-even and optional exception flags. It sits between operand-issue logic and the FPU result writeback, and accepts one operation per cycle when not stalled.

---
 rtl/fp_addsub_pipe_if.sv | 41 ++++
 rtl/fp_addsub_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for fp_addsub_pipe.
// The flags signal exists only when FP_ADDSUB_FLAGS_EN is defined.
// Both sides use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high. A source holds its data stable
// while valid is high and ready is low.
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
`ifdef FP_ADDSUB_FLAGS_EN
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags
  );
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags
  );
`else
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result
  );
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result
  );
`endif
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor, round to nearest even.
// S1 classifies and aligns, S2 adds and counts leading zeros, S3
// normalises, rounds and packs (specials override in S3).
// A result is presented on the third rising edge, counting the edge that
// accepts the operands. Exception flags are built only with
// FP_ADDSUB_FLAGS_EN defined; result is the same in both builds.
module fp_addsub_pipe #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input logic          clk,
  input logic          rst,
  fp_addsub_pipe_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int F    = MAN_W + 4;            // hidden, fraction, G, R, S
  localparam int SW   = MAN_W + 5;            // F plus carry
  localparam int CW_A = EXP_W + 2;
  localparam int CW_B = $clog2(MAN_W + 5) + 1;
  localparam int CW   = (CW_A > CW_B) ? CW_A : CW_B;  // exponent/shift math

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [CW-1:0]    MAX_EXP  = CW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0]    LIM      = CW'(F - 1);
  localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Subnormals and zeros compute with exponent 1.
  function automatic logic [CW-1:0] eff_exp(input logic [EXP_W-1:0] e);
    eff_exp = (e == '0) ? CW'(1) : CW'(e);
  endfunction

  function automatic logic [F-1:0] sig_frame(input logic [EXP_W-1:0] e,
                                             input logic [MAN_W-1:0] m);
    sig_frame = {(e != '0), m, 3'b000};
  endfunction

  function automatic logic [CW-1:0] lead_zeros(input logic [F-1:0] v);
    logic found;
    lead_zeros = CW'(F);
    found = 1'b0;
    for (int i = F - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        lead_zeros = CW'(F - 1 - i);
        found = 1'b1;
      end
    end
  endfunction

  // Pipeline control: everything moves together when the output can move.
  logic v1, v2, v3;
  logic adv;
  assign adv           = ~v3 | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3;

  // ---------------- Stage 1 ----------------
  logic             a_sign, b_sign, a_nan, b_nan, a_inf, b_inf, swap;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             big_sign, small_sign;
  logic [CW-1:0]    big_e, small_e, diff;
  logic [F-1:0]     big_frame, small_frame, shifted, aligned;
  logic             nan_in, inf_in, inf_sign_in;

  // Classify both operands, put the larger magnitude first, align the other.
  always_comb begin
    a_sign      = bus.a[W-1];
    b_sign      = bus.b[W-1] ^ bus.op;
    a_exp       = bus.a[W-2:MAN_W];
    b_exp       = bus.b[W-2:MAN_W];
    a_man       = bus.a[MAN_W-1:0];
    b_man       = bus.b[MAN_W-1:0];
    a_nan       = (a_exp == EXP_ONES) && (a_man != '0);
    b_nan       = (b_exp == EXP_ONES) && (b_man != '0);
    a_inf       = (a_exp == EXP_ONES) && (a_man == '0);
    b_inf       = (b_exp == EXP_ONES) && (b_man == '0);
    swap        = bus.b[W-2:0] > bus.a[W-2:0];
    big_sign    = swap ? b_sign : a_sign;
    small_sign  = swap ? a_sign : b_sign;
    big_e       = swap ? eff_exp(b_exp) : eff_exp(a_exp);
    small_e     = swap ? eff_exp(a_exp) : eff_exp(b_exp);
    big_frame   = swap ? sig_frame(b_exp, b_man) : sig_frame(a_exp, a_man);
    small_frame = swap ? sig_frame(a_exp, a_man) : sig_frame(b_exp, b_man);
    diff        = big_e - small_e;
    shifted     = small_frame >> diff;
    // Very large shifts leave nothing but a sticky bit.
    if (diff >= LIM) aligned = {{(F-1){1'b0}}, |small_frame};
    else             aligned = {shifted[F-1:1], shifted[0] | ((shifted << diff) != small_frame)};
    nan_in      = a_nan | b_nan | (a_inf & b_inf & (a_sign ^ b_sign));
    inf_in      = a_inf | b_inf;
    inf_sign_in = a_inf ? a_sign : b_sign;
  end

  logic          s1_sign, s1_sub, s1_nan, s1_inf, s1_inf_sign;
  logic [CW-1:0] s1_exp;
  logic [F-1:0]  s1_big, s1_small;

  // ---------------- Stage 2 ----------------
  logic [SW-1:0] sum;
  logic [CW-1:0] sum_lzc;

  // Add or subtract aligned magnitudes; larger-first ordering keeps it >= 0.
  always_comb begin
    if (s1_sub) sum = {1'b0, s1_big} - {1'b0, s1_small};
    else        sum = {1'b0, s1_big} + {1'b0, s1_small};
    sum_lzc = lead_zeros(sum[F-1:0]);
  end

  logic          s2_sign, s2_sub, s2_nan, s2_inf, s2_inf_sign;
  logic [CW-1:0] s2_exp, s2_lzc;
  logic [SW-1:0] s2_sum;

  // ---------------- Stage 3 ----------------
  logic [F-1:0]     norm;
  logic [CW-1:0]    lim, shamt, exp_n, exp_r;
  logic             rnd_up, overflow, res_sign;
  logic [MAN_W+1:0] mant;
  logic [MAN_W:0]   mant_r;
  logic [EXP_W-1:0] exp_field;
  logic [W-1:0]     nxt_result;

  // Normalise (limited so the exponent never drops below 1), round, pack.
  always_comb begin
    norm  = '0;
    shamt = '0;
    exp_n = '0;
    lim   = s2_exp - CW'(1);
    if (s2_sum[SW-1]) begin
      norm  = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
      exp_n = s2_exp + CW'(1);
    end else begin
      shamt = (s2_lzc < lim) ? s2_lzc : lim;
      norm  = s2_sum[F-1:0] << shamt;
      exp_n = s2_exp - shamt;
    end
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant   = {1'b0, norm[F-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    if (mant[MAN_W+1]) begin
      mant_r = mant[MAN_W+1:1];
      exp_r  = exp_n + CW'(1);
    end else begin
      mant_r = mant[MAN_W:0];
      exp_r  = exp_n;
    end
    overflow  = mant_r[MAN_W] && (exp_r >= MAX_EXP);
    // An exact zero is +0 unless both operands were zeros of the same sign.
    res_sign  = (s2_sum == '0) ? (s2_sign & ~s2_sub) : s2_sign;
    exp_field = mant_r[MAN_W] ? exp_r[EXP_W-1:0] : '0;
    if (s2_nan)        nxt_result = QNAN;
    else if (s2_inf)   nxt_result = {s2_inf_sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (overflow) nxt_result = {res_sign, EXP_ONES, {MAN_W{1'b0}}};
    else               nxt_result = {res_sign, exp_field, mant_r[MAN_W-1:0]};
  end

  logic [W-1:0] result_q;
  assign bus.result = result_q;

  // Stage valid bits; cleared by reset so in-flight work is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Stage 1 and 2 data registers; they need no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign     <= big_sign;
      s1_sub      <= big_sign ^ small_sign;
      s1_exp      <= big_e;
      s1_big      <= big_frame;
      s1_small    <= aligned;
      s1_nan      <= nan_in;
      s1_inf      <= inf_in;
      s1_inf_sign <= inf_sign_in;
      s2_sign     <= s1_sign;
      s2_sub      <= s1_sub;
      s2_exp      <= s1_exp;
      s2_sum      <= sum;
      s2_lzc      <= sum_lzc;
      s2_nan      <= s1_nan;
      s2_inf      <= s1_inf;
      s2_inf_sign <= s1_inf_sign;
    end
  end

  // Output register; loads only real results so it holds across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            result_q <= '0;
    else if (adv && v2) result_q <= nxt_result;
  end

`ifdef FP_ADDSUB_FLAGS_EN
  logic       invalid_in, s1_invalid, s2_invalid, inexact;
  logic [3:0] nxt_flags, flags_q;
  assign bus.flags = flags_q;

  // Invalid: signalling NaN operand or opposite-signed infinities.
  always_comb begin
    invalid_in = (a_nan & ~a_man[MAN_W-1]) | (b_nan & ~b_man[MAN_W-1]) |
                 (a_inf & b_inf & (a_sign ^ b_sign));
  end

  // Flags {invalid, overflow, underflow, inexact} for the packed result.
  always_comb begin
    inexact = norm[2] | norm[1] | norm[0];
    if (s2_nan)        nxt_flags = {s2_invalid, 3'b000};
    else if (s2_inf)   nxt_flags = 4'b0000;
    else if (overflow) nxt_flags = 4'b0101;
    else               nxt_flags = {2'b00, (exp_field == '0) & inexact, inexact};
  end

  // Invalid travels with its operation through S1 and S2.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_invalid <= invalid_in;
      s2_invalid <= s1_invalid;
    end
  end

  // Flags register, aligned with result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            flags_q <= 4'b0000;
    else if (adv && v2) flags_q <= nxt_flags;
  end
`endif
endmodule
